// File: rtl/prewish_status_poller.sv
// prewish_status_poller: periodically requests a status byte over the strobe/data handshake,
// captures the reply and publishes held status, edge masks, valid/timeout pulses and an alive toggle.
module prewish_status_poller #(
  parameter int         POLL_PERIOD = 100000,
  parameter int         POLL_BITS   = 17,
  parameter int         STB_LEN     = 2,
  parameter int         TIMEOUT     = 16,
  parameter int         TO_BITS     = 5,
  parameter logic [7:0] MASK        = 8'hFF
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  output logic       STB_O,
  output logic [7:0] DAT_O,
  input  logic       STB_I,
  input  logic [7:0] DAT_I,
  output logic [7:0] o_status,
  output logic [7:0] o_press,
  output logic [7:0] o_release,
  output logic       o_valid,
  output logic       o_timeout,
  output logic       o_alive
);
  localparam int REQ_BITS = $clog2(STB_LEN + 1);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  state_t               r_state;
  logic [POLL_BITS-1:0] r_poll_cnt;
  logic [REQ_BITS-1:0]  r_req_cnt;
  logic [TO_BITS-1:0]   r_wait_cnt;
  logic [7:0]           w_press;
  assign w_press = DAT_I & ~o_status;
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state    <= S_IDLE;
      r_poll_cnt <= POLL_BITS'(POLL_PERIOD - 1);
      r_req_cnt  <= '0;
      r_wait_cnt <= '0;
      STB_O      <= 1'b0;
      DAT_O      <= '0;
      o_status   <= '0;
      o_press    <= '0;
      o_release  <= '0;
      o_valid    <= 1'b0;
      o_timeout  <= 1'b0;
      o_alive    <= 1'b0;
    end else begin
      o_press   <= '0;
      o_release <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
      case (r_state)
        S_IDLE:
          if (r_poll_cnt == '0) begin
            r_state   <= S_REQ;
            STB_O     <= 1'b1;
            DAT_O     <= MASK;
            r_req_cnt <= REQ_BITS'(STB_LEN - 1);
          end else r_poll_cnt <= r_poll_cnt - 1'b1;
        S_REQ:
          if (r_req_cnt == '0) begin
            r_state    <= S_WAIT;
            STB_O      <= 1'b0;
            DAT_O      <= '0;
            r_wait_cnt <= TO_BITS'(TIMEOUT - 1);
          end else r_req_cnt <= r_req_cnt - 1'b1;
        S_WAIT:
          // a return strobe on the final wait cycle still wins over the timeout
          if (STB_I) begin
            o_status   <= DAT_I;
            o_press    <= w_press;
            o_release  <= ~DAT_I & o_status;
            o_valid    <= 1'b1;
            o_alive    <= o_alive ^ (|w_press);
            r_state    <= S_IDLE;
            r_poll_cnt <= POLL_BITS'(POLL_PERIOD - 1);
          end else if (r_wait_cnt == '0) begin
            o_timeout  <= 1'b1;
            r_state    <= S_IDLE;
            r_poll_cnt <= POLL_BITS'(POLL_PERIOD - 1);
          end else r_wait_cnt <= r_wait_cnt - 1'b1;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/prewish_status_poller.md
# prewish_status_poller

Initiator side of the prewish strobe/data status handshake. The block periodically requests a status byte from a responder such as the button debouncer, waits for the responder's one-cycle return strobe, and captures the returned byte. It then publishes the held status, one-cycle press/release edge masks, a valid pulse and a timeout pulse to downstream logic (blinky control, mode selection).

## Interface
Parameters:
- POLL_PERIOD, 100000: cycles from return to IDLE until the next request; minimum 1.
- POLL_BITS, 17: width of the poll counter; must satisfy 2^POLL_BITS >= POLL_PERIOD.
- STB_LEN, 2: number of cycles STB_O is held high per request; minimum 1.
- TIMEOUT, 16: maximum cycles spent in WAIT before the request is abandoned; minimum 1.
- TO_BITS, 5: width of the wait counter; must satisfy 2^TO_BITS >= TIMEOUT.
- MASK, 8'hFF: value driven on DAT_O during a request.

Ports:
- CLK_I  input  1  single clock; all state changes on its rising edge.
- RST_I  input  1  reset, asynchronous and active-high.
- STB_O  output  1  request strobe to the responder's STB_I.
- DAT_O  output  8  request data to the responder's DAT_I; equals MASK while STB_O=1, otherwise 0.
- STB_I  input  1  return strobe from the responder's STB_O.
- DAT_I  input  8  status byte from the responder's DAT_O; sampled only when STB_I=1 in WAIT.
- o_status  output  8  last captured status byte, held between captures.
- o_press  output  8  one-cycle mask of bits that went 0→1 at a capture.
- o_release  output  8  one-cycle mask of bits that went 1→0 at a capture.
- o_valid  output  1  one-cycle pulse, asserted in the cycle o_status/o_press/o_release update.
- o_timeout  output  1  one-cycle pulse when a request is abandoned.
- o_alive  output  1  toggles on every capture where the press mask is nonzero.

## Operation
- All outputs are registered. States are IDLE, REQ and WAIT.
- **IDLE**
  - poll_cnt counts down each cycle.
  - When poll_cnt==0: go to REQ, set STB_O=1 and DAT_O=MASK, load req_cnt=STB_LEN-1.
- **REQ**
  - req_cnt counts down each cycle.
  - When req_cnt==0: go to WAIT, set STB_O=0 and DAT_O=0, load wait_cnt=TIMEOUT-1.
- **WAIT, response received** (STB_I=1):
  - o_status<=DAT_I.
  - o_press<=DAT_I & ~o_status.
  - o_release<=~DAT_I & o_status.
  - o_valid<=1.
  - Toggle o_alive if (DAT_I & ~o_status)!=0.
  - Go to IDLE and load poll_cnt=POLL_PERIOD-1.
- **WAIT, no response** (STB_I=0):
  - If wait_cnt==0: o_timeout<=1, o_status unchanged, press/release stay 0, go to IDLE and reload poll_cnt.
  - Otherwise decrement wait_cnt.
- **Simultaneous events:** STB_I=1 in the same cycle wait_cnt==0 counts as a response. o_timeout is not asserted.
- **Stray strobes:** STB_I=1 in IDLE or REQ is ignored. The next capture happens only in WAIT.
- **Pulse outputs:** o_press, o_release, o_valid and o_timeout are 0 in every cycle other than their event cycle.
- **After reset:** the previous-status reference is 0, so the first capture reports any bits already high as presses.

## Timing
- **Reset values:** STB_O=0, DAT_O=0, o_status=0, o_press=0, o_release=0, o_valid=0, o_timeout=0, o_alive=0.
- **Reset state:** state=IDLE, poll_cnt=POLL_PERIOD-1. Asserting reset mid-request drops STB_O immediately, asynchronously.
- **First request:** STB_O rises POLL_PERIOD edges after reset release.
- **Handshake with the debouncer responder.** Let edge t be the edge at which STB_O rises. Then:
  - Responder latches its data at edge t+1.
  - STB_O falls at edge t+STB_LEN.
  - Responder STB_O=1 after edge t+STB_LEN+1.
  - o_valid=1 after edge t+STB_LEN+2.
- **Request period:**
  - Steady-state period is POLL_PERIOD+STB_LEN+(cycles in WAIT).
  - A timed-out request occupies exactly TIMEOUT cycles in WAIT.

## Test plan
Bench configuration: POLL_PERIOD=8, STB_LEN=2, TIMEOUT=6, MASK=8'h01, with a behavioral responder that mirrors the debouncer handshake. The responder latches its data on request, waits for the request strobe to fall, then returns a one-cycle strobe.
- Reset release, responder byte 8'h00 → STB_O rises at edge 8 with DAT_O=8'h01 for 2 cycles; o_valid pulses with o_status=0, o_press=0, o_release=0, o_alive=0.
- Responder byte changes 8'h00→8'h01 → next capture gives o_press=8'h01, o_release=0, o_alive=1; following capture with 8'h01 gives o_press=0, o_alive stays 1.
- Responder byte changes 8'h01→8'h00 → o_release=8'h01, o_press=0, o_status=0, o_alive unchanged.
- Responder silent → o_timeout pulses exactly 6 cycles after STB_O falls; o_status holds its prior value; the next request starts after 8 more cycles.
- Return strobe arrives in the last WAIT cycle with byte 8'hA5 → o_valid=1, o_timeout=0, o_status=8'hA5.
- Stray STB_I=1 during IDLE and REQ → no o_valid pulse; reset asserted while STB_O=1 → STB_O=0 and all outputs 0 before the next clock edge.
